// File: rtl/tlp_length_scheduler_if.sv
// Bus bundle for tlp_length_scheduler: length capture inputs, head-of-FIFO handshake and status.
// Defining TLP_LEN_SCHED_STATS_EN adds the tlp_cnt / max_occ statistics signals.
interface tlp_length_scheduler_if #(
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned OW = $clog2(DEPTH) + 1;

    logic [79:0]   length_in;
    logic          wr_in;
    logic [2:0]    gen;
    logic [4:0]    len_out;
    logic          len_valid;
    logic          len_ready;
    logic [OW-1:0] occupancy;
    logic          overflow;
    logic [7:0]    drop_cnt;
    logic          flushing;

`ifdef TLP_LEN_SCHED_STATS_EN
    logic [15:0]   tlp_cnt;
    logic [OW-1:0] max_occ;

    modport master (
        output length_in, wr_in, gen, len_ready,
        input  len_out, len_valid, occupancy, overflow, drop_cnt, flushing, tlp_cnt, max_occ
    );
    modport slave (
        input  length_in, wr_in, gen, len_ready,
        output len_out, len_valid, occupancy, overflow, drop_cnt, flushing, tlp_cnt, max_occ
    );
`else
    modport master (
        output length_in, wr_in, gen, len_ready,
        input  len_out, len_valid, occupancy, overflow, drop_cnt, flushing
    );
    modport slave (
        input  length_in, wr_in, gen, len_ready,
        output len_out, len_valid, occupancy, overflow, drop_cnt, flushing
    );
`endif
endinterface

// File: rtl/tlp_length_scheduler.sv
// Compacts up to MAX_IN nonzero TLP lengths per cycle into an in-order FIFO served over valid/ready.
// Optional statistics outputs (tlp_cnt, max_occ) are built when TLP_LEN_SCHED_STATS_EN is defined.
module tlp_length_scheduler #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned MAX_IN = 4
) (
    input logic                   pclk,
    input logic                   reset_n,
    tlp_length_scheduler_if.slave bus
);
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned OW  = AW + 1;
    localparam int unsigned OW1 = OW + 1;
    localparam logic [OW:0] DEPTH_W = OW1'(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [1:0]        r_state, w_state_d;
    logic [2:0]        r_gen;
    logic [AW-1:0]     r_wr_ptr, r_rd_ptr, w_wr_ptr_d, w_rd_ptr_d;
    logic [OW-1:0]     r_occ, w_occ_d, w_remain, w_n;
    logic [4:0]        r_mem [DEPTH];
    logic [4:0]        r_len_out, w_len_out_d, w_first, w_head;
    logic              r_len_valid, w_valid_d;
    logic              r_overflow;
    logic [7:0]        r_drop_cnt;
    logic [MAX_IN-1:0] w_nz;
    logic [AW-1:0]     w_rank [MAX_IN];
    logic              w_gen_change, w_cap, w_fit, w_push, w_drop, w_pop;
    logic              w_unused;

    assign w_unused = ^bus.length_in[79:5*MAX_IN];

    // Each nonzero slot gets its rank among the nonzero slots: its offset from the write pointer
    always_comb begin
        w_n     = '0;
        w_first = '0;
        w_nz    = '0;
        for (int k = 0; k < MAX_IN; k++) begin
            w_rank[k] = w_n[AW-1:0];
            w_nz[k]   = (bus.length_in[5*k +: 5] != 5'd0);
            if (w_nz[k]) w_n = w_n + OW'(1);
        end
        for (int k = MAX_IN - 1; k >= 0; k--) begin
            if (w_nz[k]) w_first = bus.length_in[5*k +: 5];
        end
    end

    assign w_gen_change = (bus.gen != r_gen);
    assign w_pop        = r_len_valid && bus.len_ready;
    assign w_fit        = ({1'b0, r_occ} + {1'b0, w_n}) <= DEPTH_W;
    assign w_cap        = bus.wr_in && (bus.gen inside {3'b011, 3'b100, 3'b101}) &&
                          (r_state != ST_FLUSH) && !w_gen_change && (w_n != '0);
    assign w_push       = w_cap && w_fit;
    assign w_drop       = w_cap && !w_fit;

    always_comb begin
        w_remain   = r_occ - (w_pop ? OW'(1) : '0);
        w_occ_d    = w_remain + (w_push ? w_n : '0);
        w_wr_ptr_d = r_wr_ptr + (w_push ? w_n[AW-1:0] : '0);
        w_rd_ptr_d = r_rd_ptr + (w_pop ? AW'(1) : '0);
        if (w_gen_change) begin
            w_state_d  = ST_FLUSH;
            w_occ_d    = '0;
            w_wr_ptr_d = '0;
            w_rd_ptr_d = '0;
        end else if (r_state == ST_FLUSH) begin
            w_state_d = ST_IDLE;
        end else begin
            w_state_d = (w_occ_d != '0) ? ST_RUN : ST_IDLE;
        end
        w_valid_d   = (w_occ_d != '0) && (w_state_d != ST_FLUSH);
        // Draining to empty before this push means the new head is still on the input bus
        w_head      = (w_remain == '0) ? w_first : r_mem[w_rd_ptr_d];
        w_len_out_d = w_valid_d ? w_head : '0;
    end

    always_ff @(posedge pclk) begin
        for (int k = 0; k < MAX_IN; k++) begin
            if (w_push && w_nz[k]) r_mem[r_wr_ptr + w_rank[k]] <= bus.length_in[5*k +: 5];
        end
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_gen       <= 3'b000;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_occ       <= '0;
            r_len_out   <= '0;
            r_len_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            r_state     <= w_state_d;
            r_gen       <= bus.gen;
            r_wr_ptr    <= w_wr_ptr_d;
            r_rd_ptr    <= w_rd_ptr_d;
            r_occ       <= w_occ_d;
            r_len_out   <= w_len_out_d;
            r_len_valid <= w_valid_d;
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

`ifdef TLP_LEN_SCHED_STATS_EN
    logic [15:0]   r_tlp_cnt;
    logic [OW-1:0] r_max_occ;

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            r_tlp_cnt <= '0;
            r_max_occ <= '0;
        end else if (w_gen_change) begin
            r_tlp_cnt <= '0;
            r_max_occ <= '0;
        end else begin
            if (w_pop) r_tlp_cnt <= r_tlp_cnt + 16'd1;
            if (w_occ_d > r_max_occ) r_max_occ <= w_occ_d;
        end
    end

    assign bus.tlp_cnt = r_tlp_cnt;
    assign bus.max_occ = r_max_occ;
`endif

    assign bus.len_out   = r_len_out;
    assign bus.len_valid = r_len_valid;
    assign bus.occupancy = r_occ;
    assign bus.overflow  = r_overflow;
    assign bus.drop_cnt  = r_drop_cnt;
    assign bus.flushing  = (r_state == ST_FLUSH);
endmodule

// File: tb/tb_tlp_length_scheduler.sv
// Directed scenarios plus randomized traffic, checked every cycle against a queue-based model.
module tb_tlp_length_scheduler;
    localparam int unsigned DEPTH = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    tlp_length_scheduler_if #(.DEPTH(DEPTH)) bus ();

    tlp_length_scheduler #(.DEPTH(DEPTH), .MAX_IN(4)) dut (
        .pclk    (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    int tests  = 0;
    int fails  = 0;
    bit chk_en = 1'b0;

    // Reference model: queue of pending lengths
    logic [4:0]  m_q[$];
    logic [2:0]  m_gen;
    bit          m_flush;
    bit          m_ovf;
    int          m_drop;
    int          m_hwm;
    logic [15:0] m_pops;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_gen   = 3'b000;
        m_flush = 1'b0;
        m_ovf   = 1'b0;
        m_drop  = 0;
        m_hwm   = 0;
        m_pops  = '0;
    endtask

    task automatic model_step();
        logic [4:0] inc[$];
        int         pre;
        bit         pop;
        pop = (m_q.size() != 0) && !m_flush && bus.len_ready;
        if (bus.gen != m_gen) begin
            m_q.delete();
            m_flush = 1'b1;
            m_pops  = '0;
            m_hwm   = 0;
        end else begin
            pre = m_q.size();
            if (pop) begin
                void'(m_q.pop_front());
                m_pops = m_pops + 16'd1;
            end
            if (bus.wr_in && (bus.gen inside {3'd3, 3'd4, 3'd5}) && !m_flush) begin
                for (int k = 0; k < 4; k++)
                    if (bus.length_in[5*k +: 5] != 5'd0) inc.push_back(bus.length_in[5*k +: 5]);
                if (inc.size() != 0) begin
                    if (pre + inc.size() <= DEPTH) begin
                        foreach (inc[i]) m_q.push_back(inc[i]);
                    end else begin
                        m_ovf = 1'b1;
                        if (m_drop < 255) m_drop++;
                    end
                end
            end
            m_flush = 1'b0;
            if (m_q.size() > m_hwm) m_hwm = m_q.size();
        end
        m_gen = bus.gen;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    initial begin
        bit ev;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                ev = (m_q.size() != 0) && !m_flush;
                check("cmp_valid", int'(bus.len_valid), int'(ev));
                if (ev) check("cmp_len_out", int'(bus.len_out), int'(m_q[0]));
                check("cmp_occupancy", int'(bus.occupancy), m_q.size());
                check("cmp_overflow", int'(bus.overflow), int'(m_ovf));
                check("cmp_drop_cnt", int'(bus.drop_cnt), m_drop);
                check("cmp_flushing", int'(bus.flushing), int'(m_flush));
`ifdef TLP_LEN_SCHED_STATS_EN
                check("cmp_tlp_cnt", int'(bus.tlp_cnt), int'(m_pops));
                check("cmp_max_occ", int'(bus.max_occ), m_hwm);
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr4(input int a, input int b, input int c, input int d);
        bus.length_in         = '0;
        bus.length_in[4:0]    = 5'(a);
        bus.length_in[9:5]    = 5'(b);
        bus.length_in[14:10]  = 5'(c);
        bus.length_in[19:15]  = 5'(d);
        bus.wr_in             = 1'b1;
    endtask

    task automatic idle_in();
        bus.wr_in     = 1'b0;
        bus.length_in = '0;
    endtask

    task automatic check_zero_state(input string tag);
        check({tag, "_valid"}, int'(bus.len_valid), 0);
        check({tag, "_len_out"}, int'(bus.len_out), 0);
        check({tag, "_occ"}, int'(bus.occupancy), 0);
        check({tag, "_ovf"}, int'(bus.overflow), 0);
        check({tag, "_drop"}, int'(bus.drop_cnt), 0);
        check({tag, "_flushing"}, int'(bus.flushing), 0);
`ifdef TLP_LEN_SCHED_STATS_EN
        check({tag, "_tlp_cnt"}, int'(bus.tlp_cnt), 0);
        check({tag, "_max_occ"}, int'(bus.max_occ), 0);
`endif
    endtask

    initial begin
        int r;
        int rdy_pct;
        idle_in();
        bus.gen       = 3'b000;
        bus.len_ready = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_state("reset");

        // Gen 0 -> 3 on the first cycle after reset counts as a change
        rst_n   = 1'b1;
        bus.gen = 3'b011;
        step();
        check("flush_after_reset", int'(bus.flushing), 1);
        chk_en = 1'b1;
        step();
        check("flush_one_cycle", int'(bus.flushing), 0);

        // Single set 3,7,0,12
        bus.len_ready = 1'b1;
        wr4(3, 7, 0, 12);
        step();
        idle_in();
        check("single_out0", int'(bus.len_out), 3);
        check("single_valid0", int'(bus.len_valid), 1);
        check("single_occ_peak", int'(bus.occupancy), 3);
        check("model_occ_peak", m_q.size(), 3);
        step();
        check("single_out1", int'(bus.len_out), 7);
        step();
        check("single_out2", int'(bus.len_out), 12);
        step();
        check("single_drained", int'(bus.len_valid), 0);

        // Backpressure
        bus.len_ready = 1'b0;
        wr4(3, 7, 0, 12);
        step();
        idle_in();
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", int'(bus.len_out), 3);
            step();
        end
        bus.len_ready = 1'b1;
        step();
        check("bp_out1", int'(bus.len_out), 7);
        step();
        check("bp_out2", int'(bus.len_out), 12);
        step();
        check("bp_drained", int'(bus.occupancy), 0);

        // Overflow: fifth full set is dropped
        bus.len_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr4(i + 1, i + 2, i + 3, i + 4);
            step();
            check("ovf_occ", int'(bus.occupancy), (i < 4) ? 4 * (i + 1) : 16);
            check("ovf_flag", int'(bus.overflow), (i == 4) ? 1 : 0);
        end
        idle_in();
        check("ovf_drop_cnt", int'(bus.drop_cnt), 1);
        check("model_drop_cnt", m_drop, 1);

        // Simultaneous push/pop near full
        bus.len_ready = 1'b1;
        step();
        step();
        check("nf_occ14", int'(bus.occupancy), 14);
        wr4(5, 0, 6, 0);
        step();
        check("nf_admit_occ15", int'(bus.occupancy), 15);
        check("nf_admit_drop", int'(bus.drop_cnt), 1);
        wr4(0, 8, 0, 9);
        step();
        idle_in();
        check("nf_drop_occ14", int'(bus.occupancy), 14);
        check("nf_drop_cnt2", int'(bus.drop_cnt), 2);

        // Gen change with 6 queued and a concurrent write
        repeat (8) step();
        bus.len_ready = 1'b0;
        check("gc_occ6", int'(bus.occupancy), 6);
        bus.gen = 3'b100;
        wr4(1, 1, 1, 1);
        step();
        check("gc_flushing", int'(bus.flushing), 1);
        check("gc_valid", int'(bus.len_valid), 0);
        check("gc_occ", int'(bus.occupancy), 0);
        step();
        idle_in();
        check("gc_flush_done", int'(bus.flushing), 0);
        check("gc_write_ignored", int'(bus.occupancy), 0);
        check("gc_idle_valid", int'(bus.len_valid), 0);

        // Async reset mid-drain at occupancy 5
        wr4(1, 2, 3, 4);
        step();
        wr4(5, 6, 7, 8);
        step();
        idle_in();
        bus.len_ready = 1'b1;
        repeat (3) step();
        check("ar_occ5", int'(bus.occupancy), 5);
        check("ar_valid", int'(bus.len_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check_zero_state("async_reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            step();
            rdy_pct = ((c / 500) % 2 == 0) ? 25 : 80;
            if ($urandom_range(0, 59) == 0) begin
                r = $urandom_range(0, 7);
                bus.gen = (r < 5) ? 3'(3 + r % 3) : 3'(r - 5);
            end
            bus.wr_in = ($urandom_range(0, 2) != 0);
            for (int k = 0; k < 16; k++)
                bus.length_in[5*k +: 5] = ($urandom_range(0, 2) == 0) ? 5'd0 :
                                          5'($urandom_range(1, 31));
            bus.len_ready = ($urandom_range(0, 99) < rdy_pct);
        end
        step();
        idle_in();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
